// File: rtl/biriscv_issue_queue_if.sv
// Handshake bundle between frontend decode, the issue queue and the issue stage.
// slave = the queue itself; master = the frontend/issue side driving it.
interface biriscv_issue_queue_if #(
  parameter int DEPTH_W = 2
);
  logic               flush_i;
  logic               in0_valid_i;
  logic [31:0]        in0_instr_i;
  logic [31:0]        in0_pc_i;
  logic [9:0]         in0_info_i;
  logic               in0_accept_o;
  logic               in1_valid_i;
  logic [31:0]        in1_instr_i;
  logic [31:0]        in1_pc_i;
  logic [9:0]         in1_info_i;
  logic               in1_accept_o;
  logic               out0_valid_o;
  logic [31:0]        out0_instr_o;
  logic [31:0]        out0_pc_o;
  logic [9:0]         out0_info_o;
  logic               out0_accept_i;
  logic               out1_valid_o;
  logic [31:0]        out1_instr_o;
  logic [31:0]        out1_pc_o;
  logic [9:0]         out1_info_o;
  logic               out1_accept_i;
  logic [DEPTH_W:0]   level_o;

  modport slave (
    input  flush_i,
    input  in0_valid_i, in0_instr_i, in0_pc_i, in0_info_i,
    input  in1_valid_i, in1_instr_i, in1_pc_i, in1_info_i,
    output in0_accept_o, in1_accept_o,
    output out0_valid_o, out0_instr_o, out0_pc_o, out0_info_o,
    output out1_valid_o, out1_instr_o, out1_pc_o, out1_info_o,
    input  out0_accept_i, out1_accept_i,
    output level_o
  );

  modport master (
    output flush_i,
    output in0_valid_i, in0_instr_i, in0_pc_i, in0_info_i,
    output in1_valid_i, in1_instr_i, in1_pc_i, in1_info_i,
    input  in0_accept_o, in1_accept_o,
    input  out0_valid_o, out0_instr_o, out0_pc_o, out0_info_o,
    input  out1_valid_o, out1_instr_o, out1_pc_o, out1_info_o,
    output out0_accept_i, out1_accept_i,
    input  level_o
  );
endinterface

// File: rtl/biriscv_issue_queue.sv
// Dual-push / dual-pop in-order instruction queue between decode and issue.
// Optional ISSUE_QUEUE_BYPASS_EN: zero-latency in->out path while the queue is empty.
module biriscv_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  biriscv_issue_queue_if.slave        bus
);
  localparam logic [DEPTH_W:0] LP_DEPTH = (DEPTH_W+1)'(DEPTH);

  logic [31:0]        r_instr [DEPTH];
  logic [31:0]        r_pc    [DEPTH];
  logic [9:0]         r_info  [DEPTH];
  logic [DEPTH_W-1:0] r_rd_ptr;
  logic [DEPTH_W-1:0] r_wr_ptr;
  logic [DEPTH_W:0]   r_count;

  logic [DEPTH_W:0]   w_free;
  logic               w_acc0, w_acc1, w_push0, w_push1;
  logic               w_pop0, w_pop1;
  logic               w_wr0_en, w_wr0_in1, w_wr1_en;
  logic [DEPTH_W:0]   w_n_push, w_n_pop;
  logic [DEPTH_W-1:0] w_rd1_ptr, w_wr1_ptr;
  logic               w_out0_valid, w_out1_valid;
  logic [31:0]        w_out0_instr, w_out0_pc, w_out1_instr, w_out1_pc;
  logic [9:0]         w_out0_info, w_out1_info;

  assign w_free    = LP_DEPTH - r_count;
  // Accept uses the registered count only; reset also forces both accepts low.
  assign w_acc0    = rst_i && !bus.flush_i && (w_free >= (DEPTH_W+1)'(1));
  assign w_acc1    = rst_i && !bus.flush_i && (w_free >= (DEPTH_W+1)'(2));
  assign w_push0   = bus.in0_valid_i && w_acc0;
  assign w_push1   = bus.in1_valid_i && w_acc1;
  assign w_rd1_ptr = r_rd_ptr + DEPTH_W'(1);
  assign w_wr1_ptr = r_wr_ptr + DEPTH_W'(1);

`ifdef ISSUE_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass = rst_i && !bus.flush_i && (r_count == '0);
`endif

  always_comb begin
    w_out0_valid = (r_count >= (DEPTH_W+1)'(1));
    w_out1_valid = (r_count >= (DEPTH_W+1)'(2));
    w_out0_instr = w_out0_valid ? r_instr[r_rd_ptr]  : '0;
    w_out0_pc    = w_out0_valid ? r_pc[r_rd_ptr]     : '0;
    w_out0_info  = w_out0_valid ? r_info[r_rd_ptr]   : '0;
    w_out1_instr = w_out1_valid ? r_instr[w_rd1_ptr] : '0;
    w_out1_pc    = w_out1_valid ? r_pc[w_rd1_ptr]    : '0;
    w_out1_info  = w_out1_valid ? r_info[w_rd1_ptr]  : '0;
`ifdef ISSUE_QUEUE_BYPASS_EN
    if (w_bypass) begin
      w_out0_valid = bus.in0_valid_i;
      w_out0_instr = bus.in0_valid_i ? bus.in0_instr_i : '0;
      w_out0_pc    = bus.in0_valid_i ? bus.in0_pc_i    : '0;
      w_out0_info  = bus.in0_valid_i ? bus.in0_info_i  : '0;
      w_out1_valid = bus.in1_valid_i;
      w_out1_instr = bus.in1_valid_i ? bus.in1_instr_i : '0;
      w_out1_pc    = bus.in1_valid_i ? bus.in1_pc_i    : '0;
      w_out1_info  = bus.in1_valid_i ? bus.in1_info_i  : '0;
    end
`endif
    w_pop0    = w_out0_valid && bus.out0_accept_i;
    w_pop1    = w_pop0 && w_out1_valid && bus.out1_accept_i;
    w_wr0_en  = w_push0 || w_push1;
    w_wr0_in1 = !w_push0;
    w_wr1_en  = w_push0 && w_push1;
    w_n_pop   = (DEPTH_W+1)'(w_pop0) + (DEPTH_W+1)'(w_pop1);
`ifdef ISSUE_QUEUE_BYPASS_EN
    // Bypassed slots consumed this cycle are never stored; a surviving in1 becomes the head.
    if (w_bypass) begin
      w_n_pop = '0;
      if (w_pop0) begin
        w_wr0_en  = w_push1 && !w_pop1;
        w_wr0_in1 = 1'b1;
        w_wr1_en  = 1'b0;
      end
    end
`endif
    w_n_push = (DEPTH_W+1)'(w_wr0_en) + (DEPTH_W+1)'(w_wr1_en);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + w_n_pop[DEPTH_W-1:0];
      r_wr_ptr <= r_wr_ptr + w_n_push[DEPTH_W-1:0];
      r_count  <= r_count + w_n_push - w_n_pop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr0_en) begin
      r_instr[r_wr_ptr] <= w_wr0_in1 ? bus.in1_instr_i : bus.in0_instr_i;
      r_pc[r_wr_ptr]    <= w_wr0_in1 ? bus.in1_pc_i    : bus.in0_pc_i;
      r_info[r_wr_ptr]  <= w_wr0_in1 ? bus.in1_info_i  : bus.in0_info_i;
    end
    if (w_wr1_en) begin
      r_instr[w_wr1_ptr] <= bus.in1_instr_i;
      r_pc[w_wr1_ptr]    <= bus.in1_pc_i;
      r_info[w_wr1_ptr]  <= bus.in1_info_i;
    end
  end

  assign bus.in0_accept_o = w_acc0;
  assign bus.in1_accept_o = w_acc1;
  assign bus.out0_valid_o = w_out0_valid;
  assign bus.out0_instr_o = w_out0_instr;
  assign bus.out0_pc_o    = w_out0_pc;
  assign bus.out0_info_o  = w_out0_info;
  assign bus.out1_valid_o = w_out1_valid;
  assign bus.out1_instr_o = w_out1_instr;
  assign bus.out1_pc_o    = w_out1_pc;
  assign bus.out1_info_o  = w_out1_info;
  assign bus.level_o      = r_count;
endmodule
